muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and result width in bits (legal: 8..64, even).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstN  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port inValid  input  1  request valid.
REQ-005 SHALL have port inReady  output  1  unit can accept a request.
REQ-006 SHALL have port opA  input  XLEN  operand A (multiplicand or dividend).
REQ-007 SHALL have port opB  input  XLEN  operand B (multiplier or divisor).
REQ-008 SHALL have port mdOp  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU (RV32M encoding).
REQ-009 SHALL have port kill  input  1  abort the in-flight operation.
REQ-010 SHALL have port outValid  output  1  mdOut holds a result.
REQ-011 SHALL have port outReady  input  1  consumer accepts the result.
REQ-012 SHALL have port mdOut  output  XLEN  result.
REQ-013 SHALL have port illegalOp  output  1  result came from a compiled-out operation; qualified by outValid.
REQ-014 SHALL have port busy  output  1  high in BUSY or FIX.

Function
REQ-015 SHALL implement states IDLE, BUSY, FIX, DONE; inReady=1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with inValid=1 and inReady=1, capturing opA, opB, mdOp; later input changes ignored until the next accept.
REQ-017 SHALL convert signed operands to magnitudes on accept (MULH/DIV/REM: both signed; MULHSU: only opA signed) and record the result sign.
REQ-018 SHALL process one bit per cycle in BUSY (shift-add multiply, restoring divide) for exactly XLEN cycles, counter from XLEN-1 down to 0, then enter FIX.
REQ-019 SHALL apply sign correction in FIX (one cycle), then enter DONE with outValid=1; normal latency is XLEN+2 rising edges from accept edge to first cycle of outValid=1.
REQ-020 SHALL return the low XLEN bits for MUL and the high XLEN bits of the 2*XLEN product for MULH/MULHSU/MULHU.
REQ-021 SHALL give remainder the sign of the dividend and quotient truncated toward zero.
REQ-022 SHALL on divisor 0 skip BUSY/FIX, go directly to DONE on the edge after accept: DIV/DIVU all-ones, REM/REMU = opA.
REQ-023 SHALL on signed overflow (DIV/REM, opA = most-negative, opB = -1) go directly to DONE on the edge after accept: DIV = opA, REM = 0.
REQ-024 SHALL hold mdOut, illegalOp, outValid stable in DONE while outReady=0.
REQ-025 SHALL leave DONE on an edge with outReady=1 and return to IDLE; no accept in that same edge (inReady rises the cycle after).
REQ-026 SHALL, with kill=1 on an edge in BUSY or FIX, return to IDLE without asserting outValid; kill is ignored in IDLE and DONE.

Reset
REQ-027 SHALL, while rstN=0, immediately force state IDLE, inReady=1, outValid=0, busy=0, illegalOp=0, mdOut=0, counter=0, regardless of clk.
REQ-028 SHALL discard any in-flight operation on reset without producing a result; first accept possible on the first rising edge after rstN deasserts.

Configuration
REQ-029 SHALL compile the divider in only when macro MULDIV_DIV_EN is defined; then ops 4-7 behave per REQ-018..REQ-023 and illegalOp is always 0.
REQ-030 SHALL, without MULDIV_DIV_EN, complete ops 4-7 on the edge after accept into DONE with mdOut=0, illegalOp=1; multiply ops unaffected and no divider logic synthesised.

Verification (XLEN=32, MULDIV_DIV_EN defined unless stated)
REQ-031 SHALL check MUL opA=7, opB=4, outReady=1 -> mdOut=28, outValid first high 34 edges after accept, inReady high the cycle after handshake.
REQ-032 SHALL check MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
REQ-033 SHALL check DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF, DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5 each in 1 edge, DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in 1 edge.
REQ-034 SHALL check backpressure: outReady=0 for 10 cycles in DONE -> mdOut/outValid stable, inValid ignored; outReady=1 -> IDLE next edge.
REQ-035 SHALL check kill at BUSY cycle 10 and rstN=0 pulse at BUSY cycle 20 -> IDLE, outValid never asserted, next MUL 3*3 -> 9.
REQ-036 SHALL check build without MULDIV_DIV_EN: DIV 10/2 -> mdOut=0, illegalOp=1 after 1 edge; MUL 6*7 -> 42, illegalOp=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide, one bit per cycle.
// Divider compiled in only with `define MULDIV_DIV_EN; otherwise ops 4-7 return 0 with illegalOp.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            inValid,
  output logic            inReady,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [2:0]      mdOp,
  input  logic            kill,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] mdOut,
  output logic            illegalOp,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [2*XLEN-1:0] acc, acc_nx, mul_step, prod, step;
  logic [XLEN-1:0] opnd, opnd_nx, res, res_nx, ma, mb, mul_res, fix_res;
  logic [XLEN:0] sum;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0] op, op_nx;
  logic neg, neg_nx, ill, ill_nx, sa, sb;
  assign sa = (mdOp == 3'd1 || mdOp == 3'd2 || mdOp == 3'd4 || mdOp == 3'd6) && opA[XLEN-1];
  assign sb = (mdOp == 3'd1 || mdOp == 3'd4 || mdOp == 3'd6) && opB[XLEN-1];
  assign ma = sa ? -opA : opA;
  assign mb = sb ? -opB : opB;
  // acc = {partial product, remaining multiplier bits}, shifted right each cycle
  assign sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step = {sum, acc[XLEN-1:1]};
  assign prod = neg ? -acc : acc;
  assign mul_res = op == 3'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
  logic [XLEN:0] trial, diff;
  logic [2*XLEN-1:0] div_step;
  logic [XLEN-1:0] dv;
  logic ovf;
  // acc = {remainder, dividend/quotient}, shifted left with restoring subtract
  assign trial = acc[2*XLEN-1:XLEN-1];
  assign diff = trial - {1'b0, opnd};
  assign div_step = diff[XLEN] ? {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign dv = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  assign step = op[2] ? div_step : mul_step;
  assign fix_res = op[2] ? (neg ? -dv : dv) : mul_res;
  assign ovf = !mdOp[0] && opA == {1'b1, {(XLEN-1){1'b0}}} && &opB;
`else
  assign step = mul_step;
  assign fix_res = mul_res;
`endif
  assign inReady = state == IDLE;
  assign outValid = state == DONE;
  assign busy = state == BUSY || state == FIX;
  assign mdOut = res;
  assign illegalOp = ill;
  always_comb begin
    state_nx = state;
    acc_nx = acc;
    opnd_nx = opnd;
    cnt_nx = cnt;
    op_nx = op;
    neg_nx = neg;
    res_nx = res;
    ill_nx = ill;
    case (state)
      IDLE: if (inValid) begin
        op_nx = mdOp;
        neg_nx = mdOp == 3'd6 ? sa : sa ^ sb;
        ill_nx = 1'b0;
        cnt_nx = CW'(XLEN-1);
        state_nx = BUSY;
        acc_nx = mdOp[2] ? {{XLEN{1'b0}}, ma} : {{XLEN{1'b0}}, mb};
        opnd_nx = mdOp[2] ? mb : ma;
`ifdef MULDIV_DIV_EN
        if (mdOp[2] && opB == '0) begin
          state_nx = DONE;
          res_nx = mdOp[1] ? opA : '1;
        end else if (mdOp[2] && ovf) begin
          state_nx = DONE;
          res_nx = mdOp[1] ? '0 : opA;
        end
`else
        if (mdOp[2]) begin
          state_nx = DONE;
          res_nx = '0;
          ill_nx = 1'b1;
        end
`endif
      end
      BUSY: if (kill) state_nx = IDLE;
      else begin
        acc_nx = step;
        cnt_nx = cnt - 1'b1;
        state_nx = cnt == '0 ? FIX : BUSY;
      end
      FIX: if (kill) state_nx = IDLE;
      else begin
        res_nx = fix_res;
        state_nx = DONE;
      end
      default: state_nx = outReady ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      state <= IDLE;
      acc <= '0;
      opnd <= '0;
      cnt <= '0;
      op <= '0;
      neg <= 1'b0;
      res <= '0;
      ill <= 1'b0;
    end else begin
      state <= state_nx;
      acc <= acc_nx;
      opnd <= opnd_nx;
      cnt <= cnt_nx;
      op <= op_nx;
      neg <= neg_nx;
      res <= res_nx;
      ill <= ill_nx;
    end
endmodule
